row_window_buffer: RTL and testbench
====================================

# row_window_buffer

Parametrised row store for the Conway datapath that generalises the single write-enabled register into a DEPTH-row bank. It accepts grid rows over a valid/ready handshake and, once full, streams one three-row neighbourhood window per cycle: north, centre and south. It sits between the grid memory reader and the cell-update logic. It alternates a fill phase and an emit phase.

## Interface
- WIDTH, default 8: cells per row (bits per entry), ≥1.
- DEPTH, default 8: rows per generation, ≥3.
- IDXW, default $clog2(DEPTH): derived index width, not overridden.

- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort to empty FILL state.
- in_row  input  WIDTH  row data.
- in_valid  input  1  in_row valid.
- in_ready  output  1  buffer accepts a row.
- out_north  output  WIDTH  row above centre.
- out_center  output  WIDTH  current row.
- out_south  output  WIDTH  row below centre.
- out_index  output  IDXW  row number of out_center.
- out_valid  output  1  window valid.
- out_ready  input  1  consumer takes window.

## Operation
- States: FILL, EMIT.
  - Reset enters FILL, with write pointer 0 and emit index 0.
- FILL:
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready, in_row is written to entry[wptr] and wptr increments.
  - The write of entry DEPTH-1 moves the state to EMIT and sets wptr to 0.
- EMIT:
  - in_ready=0 and out_valid=1.
  - out_center=entry[idx], out_north=entry[idx-1], out_south=entry[idx+1].
  - On out_valid&&out_ready, idx increments.
  - The handshake at idx=DEPTH-1 moves the state to FILL and sets idx to 0.
- in_valid during EMIT is ignored. The row is neither written nor consumed.
- Window outputs are a combinational read of the storage, indexed by the registered idx. They stay stable while out_valid&&!out_ready.
- clear (synchronous):
  - Forces FILL with wptr=0 and idx=0, and storage is not zeroed.
  - clear takes priority over a simultaneous in_valid or out_ready handshake; that row or window is dropped.
- Indices wrap modulo DEPTH (non-power-of-2 DEPTH uses explicit compare, not bit truncation).

## Timing
- Reset values:
  - in_ready=1 (FILL) and out_valid=0.
  - out_index=0.
  - Window outputs 0 (storage reset to 0).
- Assertion of reset_n low takes effect immediately and asynchronously, aborting any fill or emit; release is synchronous to clk.
- Fill-to-emit latency: out_valid rises the cycle after the edge that accepts the last row.
- Emit throughput: one window per cycle with out_ready held high. A full generation takes DEPTH fill cycles plus DEPTH emit cycles.
- Emit-to-fill: in_ready rises the cycle after the last window handshake.

## Configuration
- ROW_WINDOW_BUFFER_WRAP_EN defined (toroidal grid):
  - At idx=0, out_north=entry[DEPTH-1].
  - At idx=DEPTH-1, out_south=entry[0].
- ROW_WINDOW_BUFFER_WRAP_EN undefined (dead border): out_north at idx=0 and out_south at idx=DEPTH-1 are all zeros.
- All other behaviour is identical in both builds.

## Structure
- Shared package row_window_pkg holds:
  - typedef enum logic {ST_FILL, ST_EMIT} rwb_state_t;
  - function idx_next/idx_prev performing modulo-DEPTH wrap on an IDXW-bit index.
- Sub-module row_window_ctrl owns the FSM, wptr, idx, in_ready, out_valid and clear handling. It produces the write enable and write address.
- The top level holds the storage array and the window read muxes, including the border/wrap selection.

## Test plan
- WIDTH=8, DEPTH=4, WRAP_EN; write 0x01,0x02,0x04,0x08, out_ready=1 -> four windows in consecutive cycles:
  - idx0: N=0x08, C=0x01, S=0x02.
  - idx3: N=0x04, C=0x08, S=0x01.
  - in_ready returns 1 the cycle after the last window.
- Same stimulus, WRAP_EN undefined -> idx0 N=0x00; idx3 S=0x00; middle windows unchanged.
- Hold out_ready=0 for 3 cycles at idx1 -> outputs remain N=0x01, C=0x02, S=0x04 and out_index=1 until the handshake.
- Assert in_valid with 0xFF throughout EMIT -> storage unchanged, and the next generation's first write lands in entry 0.
- Drop reset_n at idx2 mid-emit -> out_valid=0 and in_ready=1 without a clock edge; out_index=0 and all window outputs 0 after release.
- clear together with in_valid when wptr=2 -> the row is dropped, wptr=0, and 4 further rows are needed before out_valid. DEPTH=3 repeats scenario 1 using rows 0x01,0x02,0x04.

Source files
------------

// File: rtl/row_window_pkg.sv
// Shared types and modulo-DEPTH index helpers for the row window buffer.
package row_window_pkg;

  typedef enum logic {ST_FILL, ST_EMIT} rwb_state_t;

  // Explicit compare keeps the wrap correct when depth is not a power of two.
  function automatic int idx_next(input int idx, input int depth);
    return (idx == depth - 1) ? 0 : idx + 1;
  endfunction

  function automatic int idx_prev(input int idx, input int depth);
    return (idx == 0) ? depth - 1 : idx - 1;
  endfunction

endpackage

// File: rtl/row_window_buffer_ctrl.sv
// Fill/emit sequencer: owns the write pointer, the emit index and both handshakes.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
module row_window_ctrl
  import row_window_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            in_valid,
  input  logic            out_ready,
  output logic            in_ready,
  output logic            out_valid,
  output logic            wr_en,
  output logic [IDXW-1:0] wr_addr,
  output logic [IDXW-1:0] idx,
  output rwb_state_t      state
);

  localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);

  logic [IDXW-1:0] wptr;

  // clear wins over a same-cycle row, so the write is suppressed here too.
  assign wr_en   = in_valid && in_ready && !clear;
  assign wr_addr = wptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_FILL;
      wptr      <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= ST_FILL;
      wptr      <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (in_valid) begin
            wptr <= IDXW'(idx_next(int'(wptr), DEPTH));
            if (wptr == LAST) begin
              state     <= ST_EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            idx <= IDXW'(idx_next(int'(idx), DEPTH));
            if (idx == LAST) begin
              state     <= ST_FILL;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_FILL;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/row_window_buffer.sv
// DEPTH-row store that emits north/centre/south windows; optional toroidal
// wrap at the grid edges is enabled by ROW_WINDOW_BUFFER_WRAP_EN.
module row_window_buffer
  import row_window_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_row,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_north,
  output logic [WIDTH-1:0] out_center,
  output logic [WIDTH-1:0] out_south,
  output logic [IDXW-1:0]  out_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dbg_state
);

`ifdef ROW_WINDOW_BUFFER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic [IDXW-1:0]  wr_addr;
  logic [IDXW-1:0]  idx;
  logic [IDXW-1:0]  idx_p;
  logic [IDXW-1:0]  idx_n;
  rwb_state_t       state;

  row_window_ctrl #(.DEPTH(DEPTH), .IDXW(IDXW)) u_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .idx       (idx),
    .state     (state)
  );

  assign dbg_state = (state == ST_EMIT);
  assign out_index = idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= in_row;
    end
  end

  assign idx_p = IDXW'(idx_prev(int'(idx), DEPTH));
  assign idx_n = IDXW'(idx_next(int'(idx), DEPTH));

  // Neighbours wrap naturally; a dead border blanks them at the grid edges.
  always_comb begin
    out_center = mem[idx];
    out_north  = mem[idx_p];
    out_south  = mem[idx_n];
    if (!WRAP && (idx == '0)) out_north = '0;
    if (!WRAP && (idx == IDXW'(DEPTH - 1))) out_south = '0;
  end

endmodule

// File: tb/tb_row_window_buffer.sv
// Self-checking bench for row_window_buffer (DEPTH=4 and DEPTH=3 instances).
module tb_row_window_buffer;

`ifdef ROW_WINDOW_BUFFER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // DEPTH=4 instance
  logic       clear, in_valid, in_ready, out_valid, out_ready, dbg_state;
  logic [7:0] in_row, out_north, out_center, out_south;
  logic [1:0] out_index;

  row_window_buffer #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_row(in_row),
    .in_valid(in_valid), .in_ready(in_ready), .out_north(out_north),
    .out_center(out_center), .out_south(out_south), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // DEPTH=3 instance
  logic       d3_clear, d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_dbg_state;
  logic [7:0] d3_in_row, d3_north, d3_center, d3_south;
  logic [1:0] d3_index;

  row_window_buffer #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .clear(d3_clear), .in_row(d3_in_row),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_north(d3_north),
    .out_center(d3_center), .out_south(d3_south), .out_index(d3_index),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .dbg_state(d3_dbg_state)
  );

  // scoreboard: {index, north, centre, south}
  logic [25:0] exp_q[$];
  logic [7:0]  model_mem[4];
  int          wptr_m;
  int          tests_run    = 0;
  int          tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [25:0] exp_win(input int i, input int depth);
    logic [7:0] n, c, s;
    c = model_mem[i];
    if (i == 0) n = WRAP ? model_mem[depth-1] : 8'h00;
    else        n = model_mem[i-1];
    if (i == depth - 1) s = WRAP ? model_mem[0] : 8'h00;
    else                s = model_mem[i+1];
    return {2'(i), n, c, s};
  endfunction

  function automatic logic [25:0] act4();
    return {out_index, out_north, out_center, out_south};
  endfunction

  // driver: one accepted row per cycle; a full generation queues its windows
  task automatic write_row(input logic [7:0] data);
    in_valid = 1'b1;
    in_row   = data;
    check("in_ready_fill", in_ready, 1);
    check("out_valid_fill", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    model_mem[wptr_m] = data;
    wptr_m++;
    if (wptr_m == 4) begin
      wptr_m = 0;
      for (int i = 0; i < 4; i++) exp_q.push_back(exp_win(i, 4));
    end
  endtask

  // consume n_win windows with out_ready high, optionally stalling at hold_idx
  task automatic drain(input int n_win, input int hold_idx, input int hold_n);
    logic [25:0] e;
    for (int i = 0; i < n_win; i++) begin
      e = exp_q.pop_front();
      if (i == hold_idx) begin
        for (int h = 0; h < hold_n; h++) begin
          out_ready = 1'b0;
          check("hold_valid", out_valid, 1);
          check("hold_window", act4(), e);
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      check("emit_valid", out_valid, 1);
      check("emit_in_ready", in_ready, 0);
      check("emit_state", dbg_state, 1);
      check("window", act4(), e);
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (n_win == 4) begin
      check("refill_in_ready", in_ready, 1);
      check("refill_out_valid", out_valid, 0);
      check("refill_state", dbg_state, 0);
    end
  endtask

  initial begin
    logic [25:0] e;
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
    d3_clear = 1'b0; d3_in_valid = 1'b0; d3_in_row = '0; d3_out_ready = 1'b0;
    wptr_m = 0;
    for (int i = 0; i < 4; i++) model_mem[i] = '0;

    // reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_window", act4(), 26'h0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // basic generation, one window per cycle
    write_row(8'h01); write_row(8'h02); write_row(8'h04); write_row(8'h08);
    drain(4, -1, 0);

    // stall at idx1 for three cycles
    write_row(8'h01); write_row(8'h02); write_row(8'h04); write_row(8'h08);
    drain(4, 1, 3);

    // in_valid with 0xFF held through emit must be ignored
    write_row(8'h10); write_row(8'h20); write_row(8'h40); write_row(8'h80);
    in_valid = 1'b1; in_row = 8'hFF;
    drain(4, -1, 0);
    in_valid = 1'b0;
    write_row(8'h11); write_row(8'h22); write_row(8'h44); write_row(8'h88);
    drain(4, -1, 0);

    // asynchronous reset at idx2 mid-emit
    write_row(8'h05); write_row(8'h06); write_row(8'h07); write_row(8'h09);
    drain(2, -1, 0);
    check("pre_rst_index", out_index, 2);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    exp_q.delete();
    wptr_m = 0;
    for (int i = 0; i < 4; i++) model_mem[i] = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_window", act4(), exp_win(0, 4));
    check("post_rst_out_valid", out_valid, 0);

    // clear with a simultaneous row at wptr=2
    write_row(8'h5A); write_row(8'hA5);
    clear = 1'b1; in_valid = 1'b1; in_row = 8'hAA;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    wptr_m = 0;
    check("clear_in_ready", in_ready, 1);
    check("clear_out_valid", out_valid, 0);
    write_row(8'h03); write_row(8'h0C); write_row(8'h30);
    check("clear_three_rows", out_valid, 0);
    write_row(8'hC0);
    drain(4, -1, 0);

    // DEPTH=3 instance
    exp_q.push_back({2'd0, (WRAP ? 8'h04 : 8'h00), 8'h01, 8'h02});
    exp_q.push_back({2'd1, 8'h01, 8'h02, 8'h04});
    exp_q.push_back({2'd2, 8'h02, 8'h04, (WRAP ? 8'h01 : 8'h00)});
    d3_in_valid = 1'b1; d3_in_row = 8'h01; @(negedge clk);
    d3_in_row = 8'h02; @(negedge clk);
    d3_in_row = 8'h04; @(negedge clk);
    d3_in_valid = 1'b0;
    d3_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      check("d3_valid", d3_out_valid, 1);
      check("d3_window", {d3_index, d3_north, d3_center, d3_south}, e);
      @(negedge clk);
    end
    d3_out_ready = 1'b0;
    check("d3_refill_in_ready", d3_in_ready, 1);
    check("d3_refill_out_valid", d3_out_valid, 0);
    check("d3_state", d3_dbg_state, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
